// File: rtl/fetch_pkg.sv
// Shared definitions for the operand fetch controller: FSM state encoding and default sizes.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_e;

  localparam int WORDSIZE = 16;
  localparam int ADDRSIZE = 5;

endpackage

// File: rtl/op_pair_reg.sv
// Operand-pair holding register: loads a new pair on request, holds it until the consumer takes it.
module op_pair_reg
  import fetch_pkg::*;
#(
  parameter int wordsize = WORDSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic [wordsize-1:0] d0_i,
  input  logic [wordsize-1:0] d1_i,
  input  logic                d1_valid_i,
  input  logic                d_last_i,
  output logic [wordsize-1:0] op0_o,
  output logic [wordsize-1:0] op1_o,
  output logic                op_valid_o,
  output logic                op1_valid_o,
  output logic                last_o
);

  logic [wordsize-1:0] op0_q, op1_q;
  logic                op_valid_q, op1_valid_q, last_q;

  // Contents only change on a load, so a stalled pair stays put until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      op0_q       <= '0;
      op1_q       <= '0;
      op_valid_q  <= 1'b0;
      op1_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else if (load_i) begin
      op0_q       <= d0_i;
      op1_q       <= d1_i;
      op_valid_q  <= 1'b1;
      op1_valid_q <= d1_valid_i;
      last_q      <= d_last_i;
    end else if (clear_i) begin
      op_valid_q  <= 1'b0;
    end
  end

  assign op0_o       = op0_q;
  assign op1_o       = op1_q;
  assign op_valid_o  = op_valid_q;
  assign op1_valid_o = op1_valid_q;
  assign last_o      = last_q;

endmodule

// File: rtl/operand_fetch_controller.sv
// Streams n words from a dual-port memory as operand pairs with a valid/ready handshake.
// Optional FETCH_STALL_CNT_EN adds a saturating stall-cycle counter output.
module operand_fetch_controller
  import fetch_pkg::*;
#(
  parameter int wordsize = WORDSIZE,
  parameter int addrsize = ADDRSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [addrsize-1:0] base,
  input  logic [addrsize:0]   count,
  output logic [addrsize-1:0] mem_addr0,
  output logic [addrsize-1:0] mem_addr1,
  input  logic [wordsize-1:0] mem_data0,
  input  logic [wordsize-1:0] mem_data1,
  output logic [wordsize-1:0] op0,
  output logic [wordsize-1:0] op1,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                op1_valid,
  output logic                last,
  output logic                busy,
  output logic                done
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  localparam logic [addrsize:0] TWO = (addrsize+1)'(2);

  fetch_state_e        state_q;
  logic [addrsize-1:0] ptr_q;
  logic [addrsize:0]   remaining_q;
  logic                busy_q, done_q;
  logic                load, clear, two_left;

  assign two_left  = (remaining_q >= TWO);
  assign load      = (state_q == S_FETCH) && (!op_valid || op_ready);
  assign clear     = (state_q == S_DRAIN) && op_valid && op_ready;
  // The pointer wraps, so the top address pairs with address 0.
  assign mem_addr0 = (state_q == S_FETCH) ? ptr_q : '0;
  assign mem_addr1 = (state_q == S_FETCH) ? ptr_q + addrsize'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              ptr_q       <= base;
              remaining_q <= count;
              busy_q      <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (load) begin
            ptr_q       <= ptr_q + addrsize'(2);
            remaining_q <= two_left ? remaining_q - TWO : '0;
            if (remaining_q <= TWO) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (clear) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  op_pair_reg #(.wordsize(wordsize)) u_pair (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .clear_i     (clear),
    .d0_i        (mem_data0),
    .d1_i        (two_left ? mem_data1 : '0),
    .d1_valid_i  (two_left),
    .d_last_i    (remaining_q <= TWO),
    .op0_o       (op0),
    .op1_o       (op1),
    .op_valid_o  (op_valid),
    .op1_valid_o (op1_valid),
    .last_o      (last)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  // op_valid is low in IDLE, so the start clear never races an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if (op_valid && !op_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_operand_fetch_controller.sv
// Self-checking bench for operand_fetch_controller against a pair-list reference model.
module tb_operand_fetch_controller;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        v;
    logic        l;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst, start, op_ready;
  logic [4:0]  base, mem_addr0, mem_addr1;
  logic [5:0]  count;
  logic [15:0] mem_data0, mem_data1, op0, op1;
  logic        op_valid, op1_valid, last, busy, done;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  logic [15:0] mem [32];
  assign mem_data0 = mem[mem_addr0];
  assign mem_data1 = mem[mem_addr1];

  always #5 clk = ~clk;

  operand_fetch_controller #(.wordsize(16), .addrsize(5)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_data0(mem_data0), .mem_data1(mem_data1),
    .op0(op0), .op1(op1), .op_valid(op_valid), .op_ready(op_ready),
    .op1_valid(op1_valid), .last(last), .busy(busy), .done(done)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int    total = 0, bad = 0;
  pair_t obs_q[$], exp_q[$];
  int    hold_err = 0, done_cnt = 0, busy_cnt = 0;
  int    job_lat, job_done_k;
  logic  prev_stall = 1'b0;
  pair_t prev_pair;

  // Passive monitor: records accepted pairs, pulse counts and hold violations.
  always @(negedge clk) begin
    pair_t cur;
    cur = '{a: op0, b: op1, v: op1_valid, l: last};
    if (op_valid && op_ready && !rst) obs_q.push_back(cur);
    if (prev_stall && !rst && (cur != prev_pair || !op_valid)) hold_err++;
    prev_stall = op_valid && !op_ready && !rst;
    prev_pair  = cur;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  // Reference: pairs taken two words at a time from base, wrapping at 32.
  task automatic build_exp(input int b, input int n);
    exp_q.delete();
    for (int w = 0; w < n; w += 2) begin
      pair_t p;
      int    a;
      a   = (b + w) % 32;
      p.a = mem[a];
      if (w + 1 < n) begin p.b = mem[(a + 1) % 32]; p.v = 1'b1; end
      else begin p.b = 16'h0; p.v = 1'b0; end
      p.l = (w + 2 >= n);
      exp_q.push_back(p);
    end
  endtask

  // mode 0: ready held 1; mode 1: random ready; mode 2: ready 1 plus start noise while busy.
  task automatic run_job(input int b, input int n, input int mode);
    @(posedge clk); #1;
    obs_q.delete(); done_cnt = 0; busy_cnt = 0; job_lat = -1; job_done_k = -1;
    base = 5'(b); count = 6'(n); start = 1'b1; op_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400 && job_done_k < 0; k++) begin
      @(negedge clk);
      if (op_valid && job_lat < 0) job_lat = k;
      if (done) job_done_k = k;
      @(posedge clk); #1;
      case (mode)
        1: op_ready = 1'($urandom_range(0, 1));
        2: begin
          op_ready = 1'b1;
          start    = busy & 1'($urandom_range(0, 1));
          base     = 5'($urandom);
          count    = 6'($urandom_range(0, 32));
        end
        default: op_ready = 1'b1;
      endcase
    end
    start = 1'b0; op_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; count = 6'd4; base = 5'd0; op_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%b want=0", op_valid); end
    total++; if ({op0, op1, op1_valid, last, done} !== 35'h0) begin bad++;
      $display("FAIL reset_outputs got=%h want=0", {op0, op1, op1_valid, last, done}); end
    total++; if ({mem_addr0, mem_addr1} !== 10'h0) begin bad++;
      $display("FAIL reset_addr got=%h want=0", {mem_addr0, mem_addr1}); end
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 32; i++) mem[i] = 16'(i + 1);
    build_exp(0, 4);
    run_job(0, 4, 0);
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL basic_npairs got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL basic_pair%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (job_lat !== 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", job_lat); end
    total++; if (job_done_k !== 3) begin bad++; $display("FAIL basic_done_time got=%0d want=3", job_done_k); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    build_exp(30, 5);
    run_job(30, 5, 0);
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL wrap_npairs got=%0d want=3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL wrap_pair%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (job_done_k !== 4) begin bad++; $display("FAIL wrap_done_time got=%0d want=4", job_done_k); end
  endtask

  task automatic test_zero;
    run_job(7, 0, 0);
    total++; if (job_lat !== -1) begin bad++; $display("FAIL zero_op_valid got=%0d want=-1", job_lat); end
    total++; if (job_done_k !== 0) begin bad++; $display("FAIL zero_done_time got=%0d want=0", job_done_k); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", busy_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_random;
    for (int j = 0; j < 6; j++) begin
      int b, n;
      b = $urandom_range(0, 31);
      n = $urandom_range(1, 32);
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      build_exp(b, n);
      run_job(b, n, 1);
      total++; if (obs_q.size() !== exp_q.size()) begin bad++;
        $display("FAIL rand%0d_npairs got=%0d want=%0d", j, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++;
          $display("FAIL rand%0d_pair%0d got=%h want=%h", j, i, obs_q[i], exp_q[i]); end
      end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", j, done_cnt); end
    end
    total++; if (hold_err !== 0) begin bad++; $display("FAIL rand_hold got=%0d want=0", hold_err); end
  endtask

  task automatic test_stall;
    int    b;
    pair_t snap;
    b = $urandom_range(0, 31);
    build_exp(b, 6);
    @(posedge clk); #1;
    base = 5'(b); count = 6'd6; start = 1'b1; op_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL stall_clear got=%0d want=0", stall_cycles); end
`endif
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      snap = '{a: op0, b: op1, v: op1_valid, l: last};
      total++; if (op_valid !== 1'b1 || snap !== exp_q[k]) begin bad++;
        $display("FAIL stall_pair%0d got=%b/%h want=1/%h", k, op_valid, snap, exp_q[k]); end
      op_ready = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        total++; if (op_valid !== 1'b1 || {op0, op1, op1_valid, last} !== snap) begin bad++;
          $display("FAIL stall_hold%0d got=%b/%h want=1/%h", k, op_valid, {op0, op1, op1_valid, last}, snap); end
      end
`ifdef FETCH_STALL_CNT_EN
      total++; if (stall_cycles !== 16'(2 * (k + 1))) begin bad++;
        $display("FAIL stall_count%0d got=%0d want=%0d", k, stall_cycles, 2 * (k + 1)); end
`endif
      op_ready = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (done !== 1'b1 || op_valid !== 1'b0) begin bad++;
      $display("FAIL stall_done got=%b%b want=10", done, op_valid); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_done_width got=%b want=0", done); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    base = 5'd3; count = 6'd10; start = 1'b1; op_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (op_valid && op_ready) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_handshake got=0 want=1"); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
    rst = 1'b1; done_cnt = 0;
    @(posedge clk); #1;
    total++; if ({op_valid, op1_valid, last, busy, done} !== 5'b0) begin bad++;
      $display("FAIL rstmid_ctrl got=%b want=00000", {op_valid, op1_valid, last, busy, done}); end
    total++; if ({op0, op1, mem_addr0, mem_addr1} !== 42'h0) begin bad++;
      $display("FAIL rstmid_data got=%h want=0", {op0, op1, mem_addr0, mem_addr1}); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (done_cnt !== 0 || busy !== 1'b0) begin bad++;
      $display("FAIL rstmid_idle got=%0d/%b want=0/0", done_cnt, busy); end
    build_exp(8, 2);
    run_job(8, 2, 0);
    total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL rstmid_npairs got=%0d want=1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL rstmid_pair got=%h want=%h", obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    build_exp(0, 32);
    run_job(0, 32, 2);
    total++; if (obs_q.size() !== 16) begin bad++; $display("FAIL full_npairs got=%0d want=16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL full_pair%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (job_done_k !== 17) begin bad++; $display("FAIL full_done_time got=%0d want=17", job_done_k); end
    total++; if (done_cnt !== 1 || busy !== 1'b0) begin bad++;
      $display("FAIL full_idle got=%0d/%b want=1/0", done_cnt, busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_ready = 1'b0; base = '0; count = '0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_random();
    test_stall();
    test_reset_mid();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
